// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with start/busy/done handshake and Z/C/N/V flags.
// Optional iterative shift-add multiplier for op 110, built when ALU_MUL_EN is defined.
// Without ALU_MUL_EN, op 110 behaves as the invalid op and busy is tied low.
module alu_seq #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic         z,
   output logic         c,
   output logic         n,
   output logic         v,
   output logic         busy,
   output logic         done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   logic [W:0]   sum_c;
   logic [W:0]   diff_c;
   logic [W-1:0] alu_res_c;
   logic         alu_c_c;
   logic         alu_v_c;
   logic         take_single_c;

   logic [W-1:0] res_d;
   logic         z_d;
   logic         c_d;
   logic         n_d;
   logic         v_d;
   logic         done_d;

`ifdef ALU_MUL_EN
   localparam logic [2:0]  OP_MUL = 3'b110;
   localparam int unsigned CW     = $clog2(W);
   localparam logic [0:0]  S_IDLE = 1'b0;
   localparam logic [0:0]  S_MUL  = 1'b1;

   logic [0:0]     state;
   logic [0:0]     state_d;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_d;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_d;
   logic [2*W-1:0] mcand;
   logic [2*W-1:0] mcand_d;
   logic [W-1:0]   mplier;
   logic [W-1:0]   mplier_d;
   logic [2*W-1:0] acc_step_c;
   logic           busy_d;

   // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
   assign acc_step_c    = acc + (mplier[0] ? mcand : {(2*W){1'b0}});
   assign take_single_c = (state == S_IDLE) && start && (op != OP_MUL);
`else
   assign take_single_c = start;
   assign busy          = 1'b0;
`endif

   // Single-cycle datapath; ops without a defined result (invalid, or MUL when not built) give 0.
   always_comb begin
      sum_c     = {1'b0, a} + {1'b0, b};
      diff_c    = {1'b0, a} - {1'b0, b};
      alu_res_c = '0;
      alu_c_c   = 1'b0;
      alu_v_c   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_c = sum_c[W-1:0];
            alu_c_c   = sum_c[W];
            alu_v_c   = (a[W-1] == b[W-1]) && (sum_c[W-1] != a[W-1]);
         end
         OP_SUB: begin
            alu_res_c = diff_c[W-1:0];
            alu_c_c   = diff_c[W];
            alu_v_c   = (a[W-1] != b[W-1]) && (diff_c[W-1] != a[W-1]);
         end
         OP_AND:  alu_res_c = a & b;
         OP_OR:   alu_res_c = a | b;
         OP_XOR:  alu_res_c = a ^ b;
         OP_NOT:  alu_res_c = ~a;
         default: alu_res_c = '0;
      endcase
   end

   // Next-state and next-output logic; outputs hold unless an operation completes.
   always_comb begin
      res_d  = res;
      z_d    = z;
      c_d    = c;
      n_d    = n;
      v_d    = v;
      done_d = 1'b0;
`ifdef ALU_MUL_EN
      state_d  = state;
      cnt_d    = cnt;
      acc_d    = acc;
      mcand_d  = mcand;
      mplier_d = mplier;
      busy_d   = busy;
      case (state)
         S_IDLE: begin
            if (start && (op == OP_MUL)) begin
               state_d  = S_MUL;
               busy_d   = 1'b1;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = {{W{1'b0}}, a};
               mplier_d = b;
            end
         end
         S_MUL: begin
            acc_d    = acc_step_c;
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
            cnt_d    = cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               res_d   = acc_step_c[W-1:0];
               c_d     = |acc_step_c[2*W-1:W];
               v_d     = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
`endif
      if (take_single_c) begin
         res_d  = alu_res_c;
         c_d    = alu_c_c;
         v_d    = alu_v_c;
         done_d = 1'b1;
      end
      if (done_d) begin
         z_d = (res_d == '0);
         n_d = res_d[W-1];
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res  <= '0;
         z    <= 1'b0;
         c    <= 1'b0;
         n    <= 1'b0;
         v    <= 1'b0;
         done <= 1'b0;
`ifdef ALU_MUL_EN
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         busy   <= 1'b0;
`endif
      end else begin
         res  <= res_d;
         z    <= z_d;
         c    <= c_d;
         n    <= n_d;
         v    <= v_d;
         done <= done_d;
`ifdef ALU_MUL_EN
         state  <= state_d;
         cnt    <= cnt_d;
         acc    <= acc_d;
         mcand  <= mcand_d;
         mplier <= mplier_d;
         busy   <= busy_d;
`endif
      end
   end

endmodule
